jt12_mod_buf: RTL and testbench
===============================

# jt12_mod_buf

Operator-history buffer and modulation adder for the FM operator pipeline. Runs a 24-slot sequencer: slots 0–5 are S1 for channels 0–5, slots 6–11 are S3, 12–17 are S2, 18–23 are S4. Stores each completed operator result in history registers and emits registered `s1..s4_enters` flags for the next slot. The combinational connection decoder returns `use_*` selects from those flags. The block then sums the selected history values into the phase-modulation word for the operator stage.

## Interface
Parameters:
- `DW`, 14: operator result width, signed.
- `MW`, 10: modulation output width, signed.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `cen`  in  1  clock enable; all state advances only when high.
- `sync`  in  1  qualified by `cen`; marks `op_result` as slot 0.
- `op_result`  in  DW  result of the slot completing this `cen`.
- `fb`  in  3  feedback level of the channel of the next slot.
- `use_prevprev1`, `use_prev2`, `use_prev1`, `use_internal_x`, `use_internal_y`  in  1 each  source selects for the next slot.
- `s1_enters`, `s2_enters`, `s3_enters`, `s4_enters`  out  1 each  one-hot operator kind of the next slot.
- `next_ch`  out  3  channel of the next slot.
- `mod_out`  out  MW  modulation word for the slot computed at the last `cen`.
- `mod_slot`  out  5  slot index `mod_out` belongs to.

## Operation
- `slot_cnt` (0–23) is the slot whose result arrives on the next `cen`.
- `cur` = 0 if `sync`, else `slot_cnt`. `nxt` = (`cur` + 1) mod 24.
- `s*_enters` and `next_ch` decode `nxt` combinationally, so `sync` takes effect in the same cycle.
- On `cen`:
  - Shift `op_result` into the 18-deep history `h`; `h[1]` is the newest entry.
  - If `cur` is in 0–5 (S1 completing): `fb1[ch] <= fb0[ch]`, then `fb0[ch] <= op_result`.
  - If `cur` is in 12–17 (S2 completing): `iy[ch] <= op_result`.
  - `slot_cnt <= nxt`.
  - Register `mod_out` and `mod_slot <= nxt`.
- Source values for `nxt`, with `ch` = `next_ch`:
  - S1 slot: `prev1` = `fb0[ch]`, `prevprev1` = `fb1[ch]`.
  - Any other slot: `prev1` = tap 6, `prevprev1` = tap 18.
  - `prev2` = tap 12; `internal_x` = `fb0[ch]`; `internal_y` = `iy[ch]`.
  - Tap k is the result of slot `nxt`−k, read before this cycle's shift.
- Sum:
  - `sum` = signed sum of all selected sources, DW+2 bits, sign-extended.
  - Unselected sources contribute 0.
- S1 slot:
  - `fb` = 0: `mod_out` = 0.
  - Otherwise: `mod_out` = low MW bits of `sum >>> (10 − fb)`, arithmetic shift.
- Other slots: `mod_out` = low MW bits of `sum >>> 1`, wrapping.
- All selects clear: `mod_out` = 0.
- The decoder guarantees at most one `s*_enters` high. `use_*` inputs are trusted as given.

## Timing
- Reset values:
  - `slot_cnt` = 0, all `h`/`fb0`/`fb1`/`iy` = 0.
  - `mod_out` = 0, `mod_slot` = 0.
  - Outputs then decode `nxt` = 1: `s1_enters` = 1, others 0, `next_ch` = 1.
- Latency: one `cen` from `op_result` capture to `mod_out` for the following slot.
- No read/write hazard: the nearest tap (6) never aliases the entry written in the same cycle.
- `cen` low: no state change, outputs hold.
- Wrap: slot 23 → 0 → 1 with no gap.
- `sync` while already at slot 0: no visible effect.
- `sync` mid-frame: the counter realigns; history is not cleared.
- `rst` mid-frame: overrides `cen`/`sync` and clears all state in one cycle.

## Configuration
- `JT12_MOD_SAT_EN` defined: non-S1 `mod_out` saturates to [−2^(MW−1), 2^(MW−1)−1] instead of wrapping.
- S1 feedback path is identical with or without the macro.
- Not defined: truncating wrap, as described in Operation.

## Structure
- Shared package `jt12_pkg`:
  - slot-count constant 24;
  - group base constants (S1 = 0, S3 = 6, S2 = 12, S4 = 18);
  - tap constants 6/12/18;
  - `DW`/`MW` defaults.
- Sub-module `jt12_sh_hist`: parameterised-depth `cen`-gated shift register with tap outputs, used for `h`.
- Channel memories (`fb0`, `fb1`, `iy`) stay inline.

## Test plan
- Reset, then hold `cen` = 0 → `s1_enters` = 1, `next_ch` = 1, `mod_out` = 0, `mod_slot` = 0.
- Drive `cen` for 24 cycles from reset → flags sequence S1×6, S3×6, S2×6, S4×6 starting at `nxt` = 1, and `mod_slot` wraps 23 → 0.
- `op_result` = 100 at slot 0, then `use_prev1` = 1 at `nxt` = 6 → `mod_out` = 50.
- S1 of ch0 over two frames with results 400 then 600; third frame `nxt` = 0, `fb` = 7, `use_prev1` = `use_prevprev1` = 1 → `mod_out` = 125 (1000 >>> 3).
- `prev1` = 8191 and `prev2` = 8191 selected on a non-S1 slot → 0x3FF without `JT12_MOD_SAT_EN`, 511 with it.
- Assert `sync` at `slot_cnt` = 9 → `next_ch` = 1, `s1_enters` = 1 in the same cycle. Assert `rst` mid-frame → every output at its reset value next cycle.

Source files
------------

// File: rtl/jt12_pkg.sv
// Shared constants and slot-decoding helpers for the FM operator pipeline.
//
// Contents:
//   SlotNum / ChNum            - sequencer length and channel count
//   BaseS1/BaseS3/BaseS2/BaseS4 - first slot of each operator group
//   TapPrev1/TapPrev2/TapPrevPrev1 - history distances (in slots)
//   HistDepth                  - operator history depth
//   DwDefault / MwDefault      - default result / modulation widths
//   op_kind_e, slot_kind(), slot_ch(), slot_next()
package jt12_pkg;

    localparam int unsigned SlotNum      = 24;
    localparam int unsigned ChNum        = 6;

    localparam int unsigned BaseS1       = 0;
    localparam int unsigned BaseS3       = 6;
    localparam int unsigned BaseS2       = 12;
    localparam int unsigned BaseS4       = 18;

    localparam int unsigned TapPrev1     = 6;
    localparam int unsigned TapPrev2     = 12;
    localparam int unsigned TapPrevPrev1 = 18;
    localparam int unsigned HistDepth    = 18;

    localparam int unsigned DwDefault    = 14;
    localparam int unsigned MwDefault    = 10;

    // Encoding follows slot order: groups of six slots are S1, S3, S2, S4.
    typedef enum logic [1:0] {OpS1, OpS3, OpS2, OpS4} op_kind_e;

    function automatic op_kind_e slot_kind(input logic [4:0] slot);
        if (slot < 5'(BaseS3)) begin
            return OpS1;
        end else if (slot < 5'(BaseS2)) begin
            return OpS3;
        end else if (slot < 5'(BaseS4)) begin
            return OpS2;
        end
        return OpS4;
    endfunction

    function automatic logic [2:0] slot_ch(input logic [4:0] slot);
        logic [4:0] base;
        unique case (slot_kind(slot))
            OpS1: base = 5'(BaseS1);
            OpS3: base = 5'(BaseS3);
            OpS2: base = 5'(BaseS2);
            OpS4: base = 5'(BaseS4);
        endcase
        return 3'(slot - base);
    endfunction

    function automatic logic [4:0] slot_next(input logic [4:0] slot);
        return (slot == 5'(SlotNum - 1)) ? 5'd0 : slot + 5'd1;
    endfunction

endpackage

// File: rtl/jt12_sh_hist.sv
// Clock-enabled shift register holding the most recent operator results.
//
// Stage 1 is the newest entry; each cen moves every entry one stage older.
// Ports:
//   clk_i, rst_i (sync, active-high), cen_i - clocking
//   din_i                                    - value shifted into stage 1
//   tap_a_o/tap_b_o/tap_c_o                  - stages TapA/TapB/TapC
//   last_o                                   - oldest stage (Depth)
module jt12_sh_hist #(
    parameter int unsigned Width = 14,
    parameter int unsigned Depth = 18,
    parameter int unsigned TapA  = 5,
    parameter int unsigned TapB  = 11,
    parameter int unsigned TapC  = 17
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cen_i,
    input  logic [Width-1:0] din_i,
    output logic [Width-1:0] tap_a_o,
    output logic [Width-1:0] tap_b_o,
    output logic [Width-1:0] tap_c_o,
    output logic [Width-1:0] last_o
);

    logic [Width-1:0] stage_q [1:Depth];
    logic [Width-1:0] stage_d [1:Depth];

    always_comb begin
        stage_d = stage_q;
        if (cen_i) begin
            stage_d[1] = din_i;
            for (int unsigned i = 2; i <= Depth; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 1; i <= Depth; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tap_a_o = stage_q[TapA];
    assign tap_b_o = stage_q[TapB];
    assign tap_c_o = stage_q[TapC];
    assign last_o  = stage_q[Depth];

endmodule

// File: rtl/jt12_mod_buf.sv
// Operator-history buffer and modulation adder.
//
// Tracks the 24-slot sequence, stores completed operator results, decodes the
// operator kind/channel of the next slot and registers the phase-modulation
// word for that slot.
// Ports:
//   clk, rst (sync, active-high), cen (clock enable)
//   sync          - with cen, marks op_result as slot 0
//   op_result     - result of the slot completing this cen
//   fb            - feedback level for the next slot's channel
//   use_*         - modulation source selects for the next slot
//   s1..s4_enters - one-hot operator kind of the next slot (combinational)
//   next_ch       - channel of the next slot (combinational)
//   mod_out       - registered modulation word
//   mod_slot      - slot that mod_out belongs to
// Build option: JT12_MOD_SAT_EN makes non-S1 mod_out saturate instead of wrap.
module jt12_mod_buf
    import jt12_pkg::*;
#(
    parameter int DW = DwDefault,
    parameter int MW = MwDefault
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          sync,
    input  logic [DW-1:0] op_result,
    input  logic [2:0]    fb,
    input  logic          use_prevprev1,
    input  logic          use_prev2,
    input  logic          use_prev1,
    input  logic          use_internal_x,
    input  logic          use_internal_y,
    output logic          s1_enters,
    output logic          s2_enters,
    output logic          s3_enters,
    output logic          s4_enters,
    output logic [2:0]    next_ch,
    output logic [MW-1:0] mod_out,
    output logic [4:0]    mod_slot
);

    localparam int SW = DW + 2;

    logic [4:0]    slot_cnt_q, slot_cnt_d;
    logic [DW-1:0] fb0_q [ChNum];
    logic [DW-1:0] fb0_d [ChNum];
    logic [DW-1:0] fb1_q [ChNum];
    logic [DW-1:0] fb1_d [ChNum];
    logic [DW-1:0] iy_q  [ChNum];
    logic [DW-1:0] iy_d  [ChNum];
    logic [MW-1:0] mod_out_q, mod_out_d;
    logic [4:0]    mod_slot_q, mod_slot_d;

    logic [4:0] cur, nxt;
    op_kind_e   cur_kind, nxt_kind;
    logic [2:0] cur_ch;

    assign cur      = (cen && sync) ? 5'd0 : slot_cnt_q;
    assign nxt      = slot_next(cur);
    assign cur_kind = slot_kind(cur);
    assign nxt_kind = slot_kind(nxt);
    assign cur_ch   = slot_ch(cur);
    assign next_ch  = slot_ch(nxt);

    always_comb begin
        s1_enters = 1'b0;
        s2_enters = 1'b0;
        s3_enters = 1'b0;
        s4_enters = 1'b0;
        unique case (nxt_kind)
            OpS1: s1_enters = 1'b1;
            OpS3: s3_enters = 1'b1;
            OpS2: s2_enters = 1'b1;
            OpS4: s4_enters = 1'b1;
        endcase
    end

    // mod_out is built for the slot after the one completing, so a distance of
    // k slots from nxt lands on history stage k-1 (read before the shift).
    logic [DW-1:0] tap_prev1, tap_prev2, tap_prevprev1, hist_oldest;

    jt12_sh_hist #(
        .Width(DW),
        .Depth(HistDepth),
        .TapA (TapPrev1 - 1),
        .TapB (TapPrev2 - 1),
        .TapC (TapPrevPrev1 - 1)
    ) u_hist (
        .clk_i  (clk),
        .rst_i  (rst),
        .cen_i  (cen),
        .din_i  (op_result),
        .tap_a_o(tap_prev1),
        .tap_b_o(tap_prev2),
        .tap_c_o(tap_prevprev1),
        .last_o (hist_oldest)
    );

    // S1 operators modulate themselves from their own previous two outputs.
    logic [DW-1:0] src_prev1, src_prevprev1;
    always_comb begin
        if (nxt_kind == OpS1) begin
            src_prev1     = fb0_q[next_ch];
            src_prevprev1 = fb1_q[next_ch];
        end else begin
            src_prev1     = tap_prev1;
            src_prevprev1 = tap_prevprev1;
        end
    end

    function automatic logic [SW-1:0] sext(input logic [DW-1:0] v);
        return {{2{v[DW-1]}}, v};
    endfunction

    logic [SW-1:0]        sum;
    logic signed [SW-1:0] sum_s, fb_shifted, half;
    logic [3:0]           fb_sh;
    logic [MW-1:0]        mod_other;
    logic                 unused_bits;

    assign sum = (use_prevprev1  ? sext(src_prevprev1)   : '0)
               + (use_prev2      ? sext(tap_prev2)       : '0)
               + (use_prev1      ? sext(src_prev1)       : '0)
               + (use_internal_x ? sext(fb0_q[next_ch])  : '0)
               + (use_internal_y ? sext(iy_q[next_ch])   : '0);

    assign sum_s      = signed'(sum);
    assign fb_sh      = 4'd10 - {1'b0, fb};
    assign fb_shifted = sum_s >>> fb_sh;
    assign half       = sum_s >>> 1;

`ifdef JT12_MOD_SAT_EN
    logic half_fits;
    // In range when every bit from MW-1 upward equals the sign bit.
    assign half_fits = (half[SW-1:MW-1] == {(SW-MW+1){half[SW-1]}});
    assign mod_other = half_fits ? half[MW-1:0] : {half[SW-1], {(MW-1){~half[SW-1]}}};
    assign unused_bits = ^{fb_shifted[SW-1:MW], hist_oldest};
`else
    assign mod_other = half[MW-1:0];
    assign unused_bits = ^{fb_shifted[SW-1:MW], half[SW-1:MW], hist_oldest};
`endif

    always_comb begin
        slot_cnt_d = slot_cnt_q;
        fb0_d      = fb0_q;
        fb1_d      = fb1_q;
        iy_d       = iy_q;
        mod_out_d  = mod_out_q;
        mod_slot_d = mod_slot_q;
        if (cen) begin
            slot_cnt_d = nxt;
            mod_slot_d = nxt;
            if (nxt_kind == OpS1) begin
                mod_out_d = (fb == 3'd0) ? '0 : fb_shifted[MW-1:0];
            end else begin
                mod_out_d = mod_other;
            end
            if (cur_kind == OpS1) begin
                fb1_d[cur_ch] = fb0_q[cur_ch];
                fb0_d[cur_ch] = op_result;
            end
            if (cur_kind == OpS2) begin
                iy_d[cur_ch] = op_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q <= '0;
            mod_out_q  <= '0;
            mod_slot_q <= '0;
            for (int i = 0; i < ChNum; i++) begin
                fb0_q[i] <= '0;
                fb1_q[i] <= '0;
                iy_q[i]  <= '0;
            end
        end else begin
            slot_cnt_q <= slot_cnt_d;
            mod_out_q  <= mod_out_d;
            mod_slot_q <= mod_slot_d;
            fb0_q      <= fb0_d;
            fb1_q      <= fb1_d;
            iy_q       <= iy_d;
        end
    end

    assign mod_out  = mod_out_q;
    assign mod_slot = mod_slot_q;

endmodule

// File: tb/tb_jt12_mod_buf.sv
// Self-checking bench for jt12_mod_buf: a behavioural model pushes the
// expected mod_out/mod_slot for every cen into a queue, popped after the edge.
module tb_jt12_mod_buf;

    logic        clk = 1'b0;
    logic        rst, cen, sync;
    logic [13:0] op_result;
    logic [2:0]  fb;
    logic        use_prevprev1, use_prev2, use_prev1, use_internal_x, use_internal_y;
    logic        s1_enters, s2_enters, s3_enters, s4_enters;
    logic [2:0]  next_ch;
    logic [9:0]  mod_out;
    logic [4:0]  mod_slot;

    jt12_mod_buf #(.DW(14), .MW(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .cen           (cen),
        .sync          (sync),
        .op_result     (op_result),
        .fb            (fb),
        .use_prevprev1 (use_prevprev1),
        .use_prev2     (use_prev2),
        .use_prev1     (use_prev1),
        .use_internal_x(use_internal_x),
        .use_internal_y(use_internal_y),
        .s1_enters     (s1_enters),
        .s2_enters     (s2_enters),
        .s3_enters     (s3_enters),
        .s4_enters     (s4_enters),
        .next_ch       (next_ch),
        .mod_out       (mod_out),
        .mod_slot      (mod_slot)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [9:0] mod;
        logic [4:0] slot;
    } exp_t;
    exp_t exp_q[$];

    // Model state: m_h[j] is the result captured j cens ago.
    int          m_slot;
    logic [13:0] m_h [1:18];
    logic [13:0] m_fb0 [6];
    logic [13:0] m_fb1 [6];
    logic [13:0] m_iy [6];
    logic [9:0]  m_mod;
    logic [4:0]  m_mod_slot;

    task automatic model_reset();
        m_slot = 0;
        for (int j = 1; j <= 18; j++) m_h[j] = '0;
        for (int c = 0; c < 6; c++) begin
            m_fb0[c] = '0;
            m_fb1[c] = '0;
            m_iy[c]  = '0;
        end
        m_mod      = '0;
        m_mod_slot = '0;
    endtask

    // u = {prevprev1, prev2, prev1, internal_x, internal_y}
    function automatic logic [9:0] model_mod(input int nxt, input logic [2:0] f,
                                             input logic [4:0] u, input logic [13:0] pp1,
                                             input logic [13:0] p2, input logic [13:0] p1,
                                             input logic [13:0] ix, input logic [13:0] iy);
        int s;
        logic signed [15:0] w;
        logic signed [15:0] r;
        s = 0;
        if (u[4]) s += $signed(pp1);
        if (u[3]) s += $signed(p2);
        if (u[2]) s += $signed(p1);
        if (u[1]) s += $signed(ix);
        if (u[0]) s += $signed(iy);
        w = 16'(s);
        if (nxt < 6) begin
            if (f == 3'd0) return 10'd0;
            r = w >>> (10 - int'(f));
            return r[9:0];
        end
        r = w >>> 1;
`ifdef JT12_MOD_SAT_EN
        if (r > 511) return 10'h1FF;
        if (r < -512) return 10'h200;
`endif
        return r[9:0];
    endfunction

    task automatic check_flags(input int nxt, input string where);
        check_eq({where, ".s1_enters"}, 32'(s1_enters), 32'(nxt / 6 == 0));
        check_eq({where, ".s3_enters"}, 32'(s3_enters), 32'(nxt / 6 == 1));
        check_eq({where, ".s2_enters"}, 32'(s2_enters), 32'(nxt / 6 == 2));
        check_eq({where, ".s4_enters"}, 32'(s4_enters), 32'(nxt / 6 == 3));
        check_eq({where, ".next_ch"}, 32'(next_ch), 32'(nxt % 6));
    endtask

    // One cen cycle; called #1 after a rising edge, returns #1 after the next.
    task automatic step(input logic [13:0] op, input logic [2:0] f, input logic [4:0] u,
                        input logic s);
        int cur, nxt, ch;
        logic [13:0] p1, pp1, p2;
        exp_t e;
        op_result = op;
        fb        = f;
        {use_prevprev1, use_prev2, use_prev1, use_internal_x, use_internal_y} = u;
        sync      = s;
        cen       = 1'b1;
        cur = s ? 0 : m_slot;
        nxt = (cur + 1) % 24;
        ch  = nxt % 6;
        #1;
        check_flags(nxt, "step");
        // Slot nxt-k completed k-1 cens before the one completing now.
        if (nxt < 6) begin
            p1  = m_fb0[ch];
            pp1 = m_fb1[ch];
        end else begin
            p1  = m_h[5];
            pp1 = m_h[17];
        end
        p2 = m_h[11];
        e.mod  = model_mod(nxt, f, u, pp1, p2, p1, m_fb0[ch], m_iy[ch]);
        e.slot = 5'(nxt);
        exp_q.push_back(e);
        @(posedge clk);
        for (int j = 18; j >= 2; j--) m_h[j] = m_h[j-1];
        m_h[1] = op;
        if (cur < 6) begin
            m_fb1[cur] = m_fb0[cur];
            m_fb0[cur] = op;
        end
        if (cur >= 12 && cur < 18) m_iy[cur-12] = op;
        m_slot = nxt;
        #1;
        check_eq("queue_has_entry", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("mod_out", 32'(mod_out), 32'(e.mod));
            check_eq("mod_slot", 32'(mod_slot), 32'(e.slot));
            m_mod      = e.mod;
            m_mod_slot = e.slot;
        end
    endtask

    task automatic idle(input int n);
        cen  = 1'b0;
        sync = 1'b0;
        op_result = 14'(~m_h[1]);
        repeat (n) begin
            @(posedge clk);
            #1;
            check_eq("hold.mod_out", 32'(mod_out), 32'(m_mod));
            check_eq("hold.mod_slot", 32'(mod_slot), 32'(m_mod_slot));
            check_flags((m_slot + 1) % 24, "hold");
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        cen  = 1'b1;
        sync = 1'($urandom);
        op_result = 14'($urandom);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        cen  = 1'b0;
        sync = 1'b0;
        model_reset();
        exp_q.delete();
        #1;
        check_eq("rst.mod_out", 32'(mod_out), 32'd0);
        check_eq("rst.mod_slot", 32'(mod_slot), 32'd0);
        check_eq("rst.s1_enters", 32'(s1_enters), 32'd1);
        check_eq("rst.s2_enters", 32'(s2_enters), 32'd0);
        check_eq("rst.s3_enters", 32'(s3_enters), 32'd0);
        check_eq("rst.s4_enters", 32'(s4_enters), 32'd0);
        check_eq("rst.next_ch", 32'(next_ch), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_step(input logic s);
        step(14'($urandom), 3'($urandom), 5'($urandom), s);
    endtask

    initial begin
        rst = 1'b0; cen = 1'b0; sync = 1'b0; op_result = '0; fb = '0;
        {use_prevprev1, use_prev2, use_prev1, use_internal_x, use_internal_y} = '0;
        model_reset();
        @(posedge clk);
        #1;

        do_reset();
        idle(3);

        // Frame 1: flag sequence, prev1 halving, mod_slot wrap.
        for (int i = 0; i < 24; i++) begin
            step((i == 0) ? 14'd100 : 14'd0, 3'd0, (i == 5) ? 5'b00100 : 5'b00000, 1'b0);
            if (i == 5) check_eq("prev1_half", 32'(mod_out), 32'd50);
        end
        check_eq("slot_wrap", 32'(mod_slot), 32'd0);

        // Frames 2-3: S1 ch0 results 400 then 600, feedback on frame 3's last step.
        for (int frame = 2; frame <= 3; frame++) begin
            for (int i = 0; i < 24; i++) begin
                if (i == 0) begin
                    step((frame == 2) ? 14'd400 : 14'd600, 3'($urandom), 5'($urandom), 1'b0);
                end else if (frame == 3 && i == 23) begin
                    step(14'($urandom), 3'd7, 5'b10100, 1'b0);
                    check_eq("s1_feedback", 32'(mod_out), 32'd125);
                end else begin
                    rand_step(1'b0);
                end
                if (frame == 2 && i == 10) idle(2);
            end
        end

        // Frame 4: prev1 + prev2 overflow on an S4 slot.
        for (int i = 0; i < 24; i++) begin
            if (i == 6 || i == 12) begin
                step(14'd8191, 3'($urandom), 5'($urandom), 1'b0);
            end else if (i == 17) begin
                step(14'($urandom), 3'($urandom), 5'b01100, 1'b0);
`ifdef JT12_MOD_SAT_EN
                check_eq("overflow_sat", 32'(mod_out), 32'd511);
`else
                check_eq("overflow_wrap", 32'(mod_out), 32'h3FF);
`endif
            end else begin
                rand_step(1'b0);
            end
        end

        // Mid-frame sync at slot_cnt 9, then sync while already at slot 0.
        for (int i = 0; i < 9; i++) rand_step(1'b0);
        sync = 1'b1;
        cen  = 1'b1;
        #1;
        check_eq("sync.next_ch", 32'(next_ch), 32'd1);
        check_eq("sync.s1_enters", 32'(s1_enters), 32'd1);
        rand_step(1'b1);
        for (int i = 0; i < 40; i++) rand_step(m_slot == 0);

        // Mid-frame reset, then realignment from slot 0.
        for (int i = 0; i < 7; i++) rand_step(1'b0);
        do_reset();
        for (int i = 0; i < 30; i++) rand_step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1);
    end

endmodule
